// File: rtl/debug_host_sequencer.sv
// Host-side UART debug protocol initiator: streams a program from a local ROM
// into the TX FIFO, then requests single steps and captures the target's state dump.
module debug_host_sequencer #(
  parameter int N       = 8,
  parameter int PC_SZ   = 32,
  parameter int W       = 5,
  parameter int PA      = 8,
  parameter int N_REG   = 31,
  parameter int N_MEM   = 31,
  parameter int TIMEOUT = 1023
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_end,
  input  logic [7:0]       i_prog_size,
  output logic [PA-1:0]    o_prog_addr,
  input  logic [PC_SZ-1:0] i_prog_word,
  output logic [N-1:0]     o_tx_data,
  output logic             o_tx_wr,
  input  logic             i_tx_full,
  input  logic [N-1:0]     i_rx_data,
  input  logic             i_rx_empty,
  output logic             o_rx_rd,
  output logic             o_dump_we,
  output logic [1:0]       o_dump_sel,
  output logic [W-1:0]     o_dump_idx,
  output logic [PC_SZ-1:0] o_dump_word,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_error,
  output logic [3:0]       o_state
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [W-1:0]  REG_LAST = W'(N_REG - 1);
  localparam logic [W-1:0]  MEM_LAST = W'(N_MEM - 1);
  localparam logic [N-1:0]  CMD_SIZE = 8'hFE;
  localparam logic [N-1:0]  CMD_DBG  = 8'hFC;
  localparam logic [N-1:0]  CMD_NEXT = 8'h01;
  localparam logic [N-1:0]  CMD_END  = 8'hF8;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    TX_SZCMD = 4'd1,
    TX_SZ    = 4'd2,
    FETCH    = 4'd3,
    TX_WORD  = 4'd4,
    TX_DBG   = 4'd5,
    READY    = 4'd6,
    TX_NEXT  = 4'd7,
    TX_END   = 4'd8,
    RX_DUMP  = 4'd9
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_size;
  logic [PA-1:0]    r_addr;
  logic [1:0]       r_byte_cnt;
  logic             r_fetch_wait;
  logic [PC_SZ-1:0] r_word;
  logic [PC_SZ-1:0] r_asm;
  logic [1:0]       r_sel;
  logic [W-1:0]     r_idx;
  logic [TW-1:0]    r_tmo;
  logic             r_dump_we;
  logic [1:0]       r_dump_sel;
  logic [W-1:0]     r_dump_idx;
  logic [PC_SZ-1:0] r_dump_word;
  logic             r_done;
  logic             r_error;
  logic [N-1:0]     w_tx_data;
  logic             w_tx_wr;
  logic             w_rx_rd;
  logic             w_last_word;

  assign w_last_word = (r_addr == PA'(r_size - 8'd1));

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode plus the FIFO strobes, which must follow full/empty in the same cycle
  always_comb begin
    w_next    = r_state;
    w_tx_data = 8'h00;
    w_tx_wr   = 1'b0;
    w_rx_rd   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_load) w_next = TX_SZCMD;
        else        w_next = IDLE;
      end
      TX_SZCMD: begin
        w_tx_data = CMD_SIZE;
        w_tx_wr   = ~i_tx_full;
        if (!i_tx_full) w_next = TX_SZ;
        else            w_next = TX_SZCMD;
      end
      TX_SZ: begin
        w_tx_data = r_size;
        w_tx_wr   = ~i_tx_full;
        if (i_tx_full)            w_next = TX_SZ;
        else if (r_size == 8'd0)  w_next = TX_DBG;
        else                      w_next = FETCH;
      end
      FETCH: begin
        if (r_fetch_wait) w_next = TX_WORD;
        else              w_next = FETCH;
      end
      TX_WORD: begin
        w_tx_data = r_word[{r_byte_cnt, 3'b000} +: 8];
        w_tx_wr   = ~i_tx_full;
        if (i_tx_full || r_byte_cnt != 2'd3) w_next = TX_WORD;
        else if (w_last_word)                 w_next = TX_DBG;
        else                                  w_next = FETCH;
      end
      TX_DBG: begin
        w_tx_data = CMD_DBG;
        w_tx_wr   = ~i_tx_full;
        if (!i_tx_full) w_next = READY;
        else            w_next = TX_DBG;
      end
      READY: begin
        if (i_end)       w_next = TX_END;
        else if (i_step) w_next = TX_NEXT;
        else             w_next = READY;
      end
      TX_NEXT: begin
        w_tx_data = CMD_NEXT;
        w_tx_wr   = ~i_tx_full;
        if (!i_tx_full) w_next = RX_DUMP;
        else            w_next = TX_NEXT;
      end
      TX_END: begin
        w_tx_data = CMD_END;
        w_tx_wr   = ~i_tx_full;
        if (!i_tx_full) w_next = IDLE;
        else            w_next = TX_END;
      end
      RX_DUMP: begin
        w_rx_rd = ~i_rx_empty;
        if (!i_rx_empty) begin
          if (r_byte_cnt == 2'd3 && r_sel == 2'd2) w_next = READY;
          else                                      w_next = RX_DUMP;
        end else if (r_tmo == TMO_LAST) begin
          w_next = IDLE;
        end else begin
          w_next = RX_DUMP;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: program streaming counters, dump assembly and timeout tracking
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_size       <= 8'd0;
      r_addr       <= '0;
      r_byte_cnt   <= 2'd0;
      r_fetch_wait <= 1'b0;
      r_word       <= '0;
      r_asm        <= '0;
      r_sel        <= 2'd0;
      r_idx        <= '0;
      r_tmo        <= '0;
      r_dump_we    <= 1'b0;
      r_dump_sel   <= 2'd0;
      r_dump_idx   <= '0;
      r_dump_word  <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_dump_we <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_error      <= 1'b0;
            r_size       <= i_prog_size;
            r_addr       <= '0;
            r_byte_cnt   <= 2'd0;
            r_fetch_wait <= 1'b0;
          end
        end
        FETCH: begin
          // ROM data is valid only on the second FETCH cycle
          r_fetch_wait <= ~r_fetch_wait;
          r_byte_cnt   <= 2'd0;
          if (r_fetch_wait) r_word <= i_prog_word;
        end
        TX_WORD: begin
          if (w_tx_wr) begin
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) r_addr <= r_addr + {{(PA-1){1'b0}}, 1'b1};
          end
        end
        TX_NEXT: begin
          r_byte_cnt <= 2'd0;
          r_sel      <= 2'd0;
          r_idx      <= '0;
          r_tmo      <= '0;
        end
        RX_DUMP: begin
          if (w_rx_rd) begin
            r_tmo      <= '0;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_asm[{r_byte_cnt, 3'b000} +: 8] <= i_rx_data;
            if (r_byte_cnt == 2'd3) begin
              r_dump_we   <= 1'b1;
              r_dump_sel  <= r_sel;
              r_dump_idx  <= r_idx;
              r_dump_word <= {i_rx_data, r_asm[23:0]};
              if (r_sel == 2'd0 && r_idx == REG_LAST) begin
                r_sel <= 2'd1;
                r_idx <= '0;
              end else if (r_sel == 2'd1 && r_idx == MEM_LAST) begin
                r_sel <= 2'd2;
                r_idx <= '0;
              end else if (r_sel == 2'd2) begin
                r_done <= 1'b1;
              end else begin
                r_idx <= r_idx + {{(W-1){1'b0}}, 1'b1};
              end
            end
          end else if (r_tmo == TMO_LAST) begin
            r_error    <= 1'b1;
            r_byte_cnt <= 2'd0;
            r_tmo      <= TMO_MAX;
          end else if (r_tmo != TMO_MAX) begin
            r_tmo <= r_tmo + {{(TW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_prog_addr = r_addr;
  assign o_tx_data   = w_tx_data;
  assign o_tx_wr     = w_tx_wr;
  assign o_rx_rd     = w_rx_rd;
  assign o_dump_we   = r_dump_we;
  assign o_dump_sel  = r_dump_sel;
  assign o_dump_idx  = r_dump_idx;
  assign o_dump_word = r_dump_word;
  assign o_busy      = (r_state != IDLE) && (r_state != READY);
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_state     = r_state;

endmodule
